// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: state codes, RV32I opcodes,
// datapath select encodings and the packed control-word layout.
package control_pkg;

  localparam logic [3:0] S_FETCH       = 4'd0;
  localparam logic [3:0] S_DECODE      = 4'd1;
  localparam logic [3:0] S_DECODE_JALR = 4'd2;
  localparam logic [3:0] S_MEMADR      = 4'd3;
  localparam logic [3:0] S_MEMREAD     = 4'd4;
  localparam logic [3:0] S_MEMWRITE    = 4'd5;
  localparam logic [3:0] S_MEMWB       = 4'd6;
  localparam logic [3:0] S_EXECUTER    = 4'd7;
  localparam logic [3:0] S_EXECUTEI    = 4'd8;
  localparam logic [3:0] S_JAL         = 4'd9;
  localparam logic [3:0] S_JALR        = 4'd10;
  localparam logic [3:0] S_BRANCH      = 4'd11;
  localparam logic [3:0] S_AUIPC       = 4'd12;
  localparam logic [3:0] S_LUI         = 4'd13;
  localparam logic [3:0] S_ALUWB       = 4'd14;
  localparam logic [3:0] S_TRAP        = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_TRAP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       is_immediate;
    logic [1:0] aluop;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       illegal_instr;
    logic       bus_error;
    logic       trap;
  } ctrl_t;

  // SYSTEM is deliberately absent: this core has no CSR/ECALL support yet.
  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR,
      OP_BRANCH, OP_AUIPC, OP_LUI, OP_FENCE: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bus: opcode/handshake in, datapath controls out.
// The master modport is the control FSM, the slave modport is the datapath.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       is_immediate;
  logic [1:0] aluop;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal_instr;
  logic       bus_error;
  logic       trap;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, is_immediate, aluop,
           alu_src_a, alu_src_b, illegal_instr, bus_error, trap
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, is_immediate, aluop,
           alu_src_a, alu_src_b, illegal_instr, bus_error, trap
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter for memory handshakes; flags the last cycle
// allowed before a bus timeout. MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam int TIMEOUT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != CNT_MAX)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      assign timeout = (count_q == TIMEOUT_W'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM with memory ready handshake and bus timeout.
// Optional trap state enabled by defining CONTROL_TRAP_EN.
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);

`ifdef CONTROL_TRAP_EN
  localparam logic [3:0] S_FAULT = S_TRAP;
`else
  localparam logic [3:0] S_FAULT = S_FETCH;
`endif

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       wait_state_s;
  logic       count_en_s;
  logic       timeout_s;
  logic       bus_err_s;
  logic       clear_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;

  assign wait_state_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);
  assign count_en_s   = wait_state_s && !bus.mem_ready;
  assign bus_err_s    = count_en_s && timeout_s;
  // A timeout in FETCH does not change state, so it must clear explicitly.
  assign clear_s      = (state_d != state_q) || bus_err_s;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_s),
    .count_en (count_en_s),
    .timeout  (timeout_s)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = (bus.opcode == OP_JALR) ? S_DECODE_JALR : S_DECODE;
        end else if (bus_err_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          OP_FENCE:          state_d = S_FETCH;
          default:           state_d = S_FAULT;
        endcase
      end
      S_DECODE_JALR: state_d = S_JALR;
      S_MEMADR:      state_d = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (bus_err_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (bus_err_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMWB, S_BRANCH, S_ALUWB: state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL, S_JALR, S_AUIPC, S_LUI: state_d = S_ALUWB;
`ifdef CONTROL_TRAP_EN
      S_TRAP:        state_d = S_FETCH;
`endif
      default:       state_d = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; only FETCH/memory states look at mem_ready.
  always_comb begin
    ctrl_s = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_a = SRCA_PC;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.pc_write  = bus.mem_ready;
        ctrl_s.ir_write  = bus.mem_ready;
        ctrl_s.bus_error = bus_err_s;
      end
      S_DECODE: begin
        ctrl_s.alu_src_b     = SRCB_IMM;
        ctrl_s.illegal_instr = !is_legal_opcode(bus.opcode);
      end
      S_DECODE_JALR, S_MEMADR: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.iord      = 1'b1;
        ctrl_s.bus_error = bus_err_s;
      end
      S_MEMWRITE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.iord      = 1'b1;
        ctrl_s.bus_error = bus_err_s;
      end
      S_MEMWB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.aluop     = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl_s.alu_src_a    = SRCA_RS1;
        ctrl_s.aluop        = ALUOP_FUNCT;
        ctrl_s.alu_src_b    = SRCB_IMM;
        ctrl_s.is_immediate = 1'b1;
      end
      S_JAL, S_JALR: begin
        ctrl_s.alu_src_a    = SRCA_PC;
        ctrl_s.alu_src_b    = SRCB_FOUR;
        ctrl_s.pc_write     = 1'b1;
        ctrl_s.pc_source    = PCSRC_ALUOUT;
        ctrl_s.is_immediate = (state_q == S_JALR);
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = SRCA_RS1;
        ctrl_s.aluop         = ALUOP_BRANCH;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = PCSRC_ALUOUT;
      end
      S_AUIPC: ctrl_s.alu_src_b = SRCB_IMM;
      S_LUI: begin
        ctrl_s.alu_src_a = SRCA_ZERO;
        ctrl_s.alu_src_b = SRCB_IMM;
      end
      S_ALUWB: ctrl_s.reg_write = 1'b1;
`ifdef CONTROL_TRAP_EN
      S_TRAP: begin
        ctrl_s.trap      = 1'b1;
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = PCSRC_TRAP;
      end
`endif
      default: ctrl_s = '0;
    endcase
  end

  // Reset silences every control output, even mid-instruction.
  always_comb begin
    if (reset) begin
      ctrl_out_s = '0;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign bus.pc_write      = ctrl_out_s.pc_write;
  assign bus.pc_write_cond = ctrl_out_s.pc_write_cond;
  assign bus.pc_source     = ctrl_out_s.pc_source;
  assign bus.iord          = ctrl_out_s.iord;
  assign bus.mem_read      = ctrl_out_s.mem_read;
  assign bus.mem_write     = ctrl_out_s.mem_write;
  assign bus.ir_write      = ctrl_out_s.ir_write;
  assign bus.mem_to_reg    = ctrl_out_s.mem_to_reg;
  assign bus.reg_write     = ctrl_out_s.reg_write;
  assign bus.is_immediate  = ctrl_out_s.is_immediate;
  assign bus.aluop         = ctrl_out_s.aluop;
  assign bus.alu_src_a     = ctrl_out_s.alu_src_a;
  assign bus.alu_src_b     = ctrl_out_s.alu_src_b;
  assign bus.illegal_instr = ctrl_out_s.illegal_instr;
  assign bus.bus_error     = ctrl_out_s.bus_error;
  assign bus.trap          = ctrl_out_s.trap;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm (MEM_TIMEOUT = 4); expected
// control words follow CONTROL_TRAP_EN when it is defined.
module tb_multicycle_control_fsm;

  // Control word: pcw pwc ps[2] iord mr mw irw m2r rw imm aluop[2] a[2] b[2] ill be trap
  localparam logic [19:0] E_ZERO   = 20'b0;
  localparam logic [19:0] E_F_W    = 20'b0_0_00_0_1_0_0_0_0_0_00_00_01_0_0_0;
  localparam logic [19:0] E_F_R    = 20'b1_0_00_0_1_0_1_0_0_0_00_00_01_0_0_0;
  localparam logic [19:0] E_F_TO   = 20'b0_0_00_0_1_0_0_0_0_0_00_00_01_0_1_0;
  localparam logic [19:0] E_DEC    = 20'b0_0_00_0_0_0_0_0_0_0_00_00_10_0_0_0;
  localparam logic [19:0] E_DECILL = 20'b0_0_00_0_0_0_0_0_0_0_00_00_10_1_0_0;
  localparam logic [19:0] E_ADR    = 20'b0_0_00_0_0_0_0_0_0_0_00_01_10_0_0_0;
  localparam logic [19:0] E_MRD    = 20'b0_0_00_1_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [19:0] E_MWR    = 20'b0_0_00_1_0_1_0_0_0_0_00_00_00_0_0_0;
  localparam logic [19:0] E_MWR_TO = 20'b0_0_00_1_0_1_0_0_0_0_00_00_00_0_1_0;
  localparam logic [19:0] E_MWB    = 20'b0_0_00_0_0_0_0_1_1_0_00_00_00_0_0_0;
  localparam logic [19:0] E_EXR    = 20'b0_0_00_0_0_0_0_0_0_0_10_01_00_0_0_0;
  localparam logic [19:0] E_EXI    = 20'b0_0_00_0_0_0_0_0_0_1_10_01_10_0_0_0;
  localparam logic [19:0] E_JAL    = 20'b1_0_01_0_0_0_0_0_0_0_00_00_01_0_0_0;
  localparam logic [19:0] E_JALR   = 20'b1_0_01_0_0_0_0_0_0_1_00_00_01_0_0_0;
  localparam logic [19:0] E_BR     = 20'b0_1_01_0_0_0_0_0_0_0_01_01_00_0_0_0;
  localparam logic [19:0] E_LUI    = 20'b0_0_00_0_0_0_0_0_0_0_00_10_10_0_0_0;
  localparam logic [19:0] E_AWB    = 20'b0_0_00_0_0_0_0_0_1_0_00_00_00_0_0_0;
  localparam logic [19:0] E_TRAP   = 20'b1_0_10_0_0_0_0_0_0_0_00_00_00_0_0_1;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JL  = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_AU  = 7'b0010111;
  localparam logic [6:0] OP_LU  = 7'b0110111;
  localparam logic [6:0] OP_FN  = 7'b0001111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [19:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [19:0] obs;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_write, bus.is_immediate,
                bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.illegal_instr, bus.bus_error,
                bus.trap};

  task automatic test_reset();
    reset = 1'b1; bus.opcode = OP_R; bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2; n_vec++;
      if (obs !== E_ZERO) begin
        n_err++; $display("FAIL reset[%0d]: got %b expected %b", i, obs, E_ZERO);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; bus.mem_ready = 1'b0;
    #2; n_vec++;
    if (obs !== E_F_W) begin
      n_err++; $display("FAIL reset_release: got %b expected %b", obs, E_F_W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    vec_t v[5] = '{'{1'b0, OP_R, 1'b1, E_F_R}, '{1'b0, OP_R, 1'b1, E_DEC},
                   '{1'b0, OP_R, 1'b1, E_EXR}, '{1'b0, OP_R, 1'b1, E_AWB},
                   '{1'b0, OP_R, 1'b0, E_F_W}};
    foreach (v[i]) begin
      reset = v[i].rst; bus.opcode = v[i].op; bus.mem_ready = v[i].rdy;
      #2; n_vec++;
      if (obs !== v[i].exp) begin
        n_err++; $display("FAIL rtype[%0d]: got %b expected %b", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dispatch();
    vec_t v[26] = '{
      '{1'b0, OP_I,  1'b1, E_F_R}, '{1'b0, OP_I,  1'b1, E_DEC}, '{1'b0, OP_I,  1'b1, E_EXI},
      '{1'b0, OP_I,  1'b1, E_AWB},
      '{1'b0, OP_AU, 1'b1, E_F_R}, '{1'b0, OP_AU, 1'b1, E_DEC}, '{1'b0, OP_AU, 1'b1, E_DEC},
      '{1'b0, OP_AU, 1'b1, E_AWB},
      '{1'b0, OP_LU, 1'b1, E_F_R}, '{1'b0, OP_LU, 1'b1, E_DEC}, '{1'b0, OP_LU, 1'b1, E_LUI},
      '{1'b0, OP_LU, 1'b1, E_AWB},
      '{1'b0, OP_SW, 1'b1, E_F_R}, '{1'b0, OP_SW, 1'b1, E_DEC}, '{1'b0, OP_SW, 1'b1, E_ADR},
      '{1'b0, OP_SW, 1'b1, E_MWR},
      '{1'b0, OP_JL, 1'b1, E_F_R}, '{1'b0, OP_JL, 1'b1, E_DEC}, '{1'b0, OP_JL, 1'b1, E_JAL},
      '{1'b0, OP_JL, 1'b1, E_AWB},
      '{1'b0, OP_JR, 1'b1, E_F_R}, '{1'b0, OP_JR, 1'b1, E_ADR}, '{1'b0, OP_JR, 1'b1, E_JALR},
      '{1'b0, OP_JR, 1'b1, E_AWB},
      '{1'b0, OP_FN, 1'b1, E_F_R}, '{1'b0, OP_FN, 1'b1, E_DEC}};
    foreach (v[i]) begin
      reset = v[i].rst; bus.opcode = v[i].op; bus.mem_ready = v[i].rdy;
      #2; n_vec++;
      if (obs !== v[i].exp) begin
        n_err++; $display("FAIL dispatch[%0d]: got %b expected %b", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Ready arrives exactly in the timeout cycle: completion must win.
  task automatic test_lw_wait();
    vec_t v[8] = '{'{1'b0, OP_LW, 1'b1, E_F_R}, '{1'b0, OP_LW, 1'b1, E_DEC},
                   '{1'b0, OP_LW, 1'b1, E_ADR}, '{1'b0, OP_LW, 1'b0, E_MRD},
                   '{1'b0, OP_LW, 1'b0, E_MRD}, '{1'b0, OP_LW, 1'b0, E_MRD},
                   '{1'b0, OP_LW, 1'b1, E_MRD}, '{1'b0, OP_LW, 1'b1, E_MWB}};
    foreach (v[i]) begin
      reset = v[i].rst; bus.opcode = v[i].op; bus.mem_ready = v[i].rdy;
      #2; n_vec++;
      if (obs !== v[i].exp) begin
        n_err++; $display("FAIL lw_wait[%0d]: got %b expected %b", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
`ifdef CONTROL_TRAP_EN
    localparam logic [19:0] AFTER = E_TRAP;
`else
    localparam logic [19:0] AFTER = E_F_W;
`endif
    vec_t v[16] = '{'{1'b0, OP_R, 1'b0, E_F_W}, '{1'b0, OP_R, 1'b0, E_F_W},
                    '{1'b0, OP_R, 1'b0, E_F_W}, '{1'b0, OP_R, 1'b0, E_F_TO},
                    '{1'b0, OP_R, 1'b0, AFTER}, '{1'b0, OP_R, 1'b0, E_F_W},
                    '{1'b0, OP_SW, 1'b1, E_F_R}, '{1'b0, OP_SW, 1'b1, E_DEC},
                    '{1'b0, OP_SW, 1'b1, E_ADR}, '{1'b0, OP_SW, 1'b0, E_MWR},
                    '{1'b0, OP_SW, 1'b0, E_MWR}, '{1'b0, OP_SW, 1'b0, E_MWR},
                    '{1'b0, OP_SW, 1'b0, E_MWR_TO}, '{1'b0, OP_SW, 1'b0, AFTER},
                    '{1'b0, OP_SW, 1'b0, E_F_W}, '{1'b0, OP_SW, 1'b0, E_F_W}};
    foreach (v[i]) begin
      reset = v[i].rst; bus.opcode = v[i].op; bus.mem_ready = v[i].rdy;
      #2; n_vec++;
      if (obs !== v[i].exp) begin
        n_err++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
`ifdef CONTROL_TRAP_EN
    localparam logic [19:0] AFTER = E_TRAP;
`else
    localparam logic [19:0] AFTER = E_F_W;
`endif
    vec_t v[7] = '{'{1'b0, OP_BAD, 1'b1, E_F_R}, '{1'b0, OP_BAD, 1'b1, E_DECILL},
                   '{1'b0, OP_BAD, 1'b0, AFTER},
                   '{1'b0, OP_SYS, 1'b1, E_F_R}, '{1'b0, OP_SYS, 1'b1, E_DECILL},
                   '{1'b0, OP_SYS, 1'b0, AFTER}, '{1'b0, OP_SYS, 1'b0, E_F_W}};
    foreach (v[i]) begin
      reset = v[i].rst; bus.opcode = v[i].op; bus.mem_ready = v[i].rdy;
      #2; n_vec++;
      if (obs !== v[i].exp) begin
        n_err++; $display("FAIL illegal[%0d]: got %b expected %b", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset abandons a pending memory read and an in-flight branch.
  task automatic test_reset_mid_op();
    vec_t v[6] = '{'{1'b0, OP_LW, 1'b1, E_F_R}, '{1'b0, OP_LW, 1'b1, E_DEC},
                   '{1'b0, OP_LW, 1'b1, E_ADR}, '{1'b1, OP_LW, 1'b0, E_ZERO},
                   '{1'b0, OP_B, 1'b1, E_F_R}, '{1'b0, OP_B, 1'b1, E_DEC}};
    foreach (v[i]) begin
      reset = v[i].rst; bus.opcode = v[i].op; bus.mem_ready = v[i].rdy;
      #2; n_vec++;
      if (obs !== v[i].exp) begin
        n_err++; $display("FAIL reset_mid[%0d]: got %b expected %b", i, obs, v[i].exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; bus.mem_ready = 1'b0;
    #2; n_vec++;
    if (obs !== E_BR) begin
      n_err++; $display("FAIL branch: got %b expected %b", obs, E_BR);
    end
    reset = 1'b1;
    #2; n_vec++;
    if (obs !== E_ZERO) begin
      n_err++; $display("FAIL branch_reset: got %b expected %b", obs, E_ZERO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #2; n_vec++;
    if (obs !== E_F_W) begin
      n_err++; $display("FAIL after_reset: got %b expected %b", obs, E_F_W);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.opcode = OP_R;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_dispatch();
    test_lw_wait();
    test_timeout();
    test_illegal();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
